cfu_ram_arbiter: RTL and testbench
==================================

// Module: cfu_ram_arbiter
// PURPOSE
// - Round-robin arbiter for the CFU's single Wishbone read master port (cfu_ram_*).
// - Shares that port between NUM_REQ word-fetch requesters, e.g. image-value fetch and filter preload.
// - Runs one classic single read cycle at a time.
// - Returns read data or an error to the requester that won arbitration.
// PARAMETERS
// - NUM_REQ   2    number of requesters (2..8)
// - ADR_W     30   word address width (byte address [31:2])
// - TIMEOUT   255  bus cycles to wait for ack/err before abort (1..65535)
// PORTS
// - clk          in   1              system clock; all logic on posedge
// - reset        in   1              synchronous, active-high reset
// - req_valid    in   NUM_REQ        per-requester fetch request
// - req_adr      in   NUM_REQ*ADR_W  word address; slice i belongs to requester i
// - req_ready    out  NUM_REQ        one-hot accept strobe
// - rsp_valid    out  NUM_REQ        one-hot, 1-cycle response pulse
// - rsp_data     out  32             read data, valid while any rsp_valid is high
// - rsp_err      out  1              qualifies rsp_valid: bus error or timeout
// - cfu_ram_adr  out  ADR_W          Wishbone address
// - cfu_ram_cyc, cfu_ram_stb  out  1 each   Wishbone cycle and strobe
// - cfu_ram_sel  out  4              constant 4'b1111
// - cfu_ram_we   out  1              constant 0
// - cfu_ram_cti  out  3              constant 0
// - cfu_ram_bte  out  2              constant 0
// - cfu_ram_dat_miso, cfu_ram_ack, cfu_ram_err  in  32/1/1   Wishbone return
// BEHAVIOUR
// - Reset (sync, active-high): state=IDLE; rr_ptr=0; timeout counter=0.
//   - All outputs 0 except cfu_ram_sel=4'b1111.
//   - Reset mid-transaction drops cyc/stb at that edge; no response is issued.
// - Requester handshake:
//   - Requester i holds req_valid[i] and its address slice stable until req_ready[i].
//   - req_ready is combinational; it is high only in IDLE, only for the winner.
//   - Accept occurs on cycle T when req_valid[i] & req_ready[i].
// - Arbitration: search from rr_ptr upward, modulo NUM_REQ; first asserted req_valid wins.
//   - After a response (ok or err), rr_ptr <= winner+1 (wraps to 0 at NUM_REQ).
//   - A lone requester may win back-to-back; with all requesting, grants rotate 0,1,..,N-1,0.
// - FSM:
//   - IDLE -> BUS on accept: latch winner index and address; cfu_ram_adr, cyc and stb registered high from T+1.
//   - BUS -> RESP on ack or err, or when the counter reaches TIMEOUT.
//     - Counter increments each BUS cycle, starting at 0.
//     - cyc/stb deassert on the edge that leaves BUS.
//   - RESP: rsp_valid[winner]=1 for exactly one cycle, then IDLE; no request is accepted in RESP.
// - Latency:
//   - Ack sampled in cycle A -> rsp_valid high in A+1.
//   - Minimum issue-to-issue spacing is 3 cycles with a zero-wait slave.
// - Data and error:
//   - On ack: rsp_data <= dat_miso, rsp_err=0.
//   - On err or timeout: rsp_data=0, rsp_err=1.
//   - ack and err in the same cycle: err wins.
// - Timeout: BUS lasts at most TIMEOUT+1 cycles. A late ack arriving in RESP or IDLE is ignored.
// - rsp_data and rsp_err hold their values outside RESP; only rsp_valid qualifies them.
// - No combinational path from cfu_ram_ack/err to any output.
// STRUCTURE
// - Shared package cfu_pkg:
//   - typedef enum logic [1:0] {ARB_IDLE, ARB_BUS, ARB_RESP} arb_state_t;
//   - localparam WB_SEL_ALL = 4'b1111.
// - Sub-module rr_pick #(NUM_REQ): combinational; inputs req vector and pointer.
//   - Outputs one-hot grant and winner index.
//   - Reused later by the CFU command scheduler.
// TESTING
// - Single request: req 0 at adr 0x100, ack after 2 waits, data 0xDEADBEEF
//   -> cyc/stb high 3 cycles, rsp_valid=01, rsp_data=0xDEADBEEF, rsp_err=0.
// - Both requesting continuously, 6 zero-wait transactions -> grant order 0,1,0,1,0,1; rr_ptr=0 at end.
// - err asserted together with ack -> rsp_err=1, rsp_data=0, rr_ptr still advances.
// - Silent slave, TIMEOUT=4 -> cyc/stb high 5 cycles, then rsp_err=1; ack injected one cycle later is ignored.
// - Reset pulsed in BUS -> next cycle cyc=stb=0, rsp_valid=0, rr_ptr=0, and a new request is accepted.
// - Requester 1 alone for 3 transactions -> each granted, addresses forwarded exactly.
// - Check throughout: cfu_ram_sel=4'b1111, we=0, cti=0, bte=0.

Source files
------------

// File: rtl/cfu_pkg.sv
// Shared CFU definitions: arbiter FSM states and Wishbone constants.
package cfu_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUS  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    localparam logic [3:0] WB_SEL_ALL = 4'b1111;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int                 pos_s;
    logic [NUM_REQ-1:0] req_sh_s;
    logic               hit_s;

    // Walk the ring once starting at ptr; only the first hit is kept.
    always_comb begin
        grant    = '0;
        idx      = '0;
        any      = 1'b0;
        pos_s    = 0;
        req_sh_s = '0;
        hit_s    = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            pos_s    = (int'(ptr) + off) % NUM_REQ;
            req_sh_s = req >> pos_s;
            hit_s    = req_sh_s[0] & ~any;
            grant    = grant | (NUM_REQ'(hit_s) << pos_s);
            idx      = hit_s ? IDX_W'(pos_s) : idx;
            any      = any | hit_s;
        end
    end

endmodule

// File: rtl/cfu_ram_arbiter.sv
// Round-robin arbiter sharing the CFU Wishbone read port among NUM_REQ word fetchers,
// one classic single read at a time, with an ack/err timeout.
module cfu_ram_arbiter
    import cfu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADR_W   = 30,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*ADR_W-1:0] req_adr,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [31:0]              rsp_data,
    output logic                     rsp_err,
    output logic [ADR_W-1:0]         cfu_ram_adr,
    output logic                     cfu_ram_cyc,
    output logic                     cfu_ram_stb,
    output logic [3:0]               cfu_ram_sel,
    output logic                     cfu_ram_we,
    output logic [2:0]               cfu_ram_cti,
    output logic [1:0]               cfu_ram_bte,
    input  logic [31:0]              cfu_ram_dat_miso,
    input  logic                     cfu_ram_ack,
    input  logic                     cfu_ram_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   winner_q, winner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               cyc_q, cyc_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;

    logic [ADR_W-1:0]   adr_arr_s [NUM_REQ];
    logic [NUM_REQ-1:0] grant_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic               pick_any_s;
    logic               accept_s;
    logic               timeout_s;
    logic [IDX_W-1:0]   next_ptr_s;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_adr
        assign adr_arr_s[g] = req_adr[g*ADR_W +: ADR_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant_s),
        .idx   (pick_idx_s),
        .any   (pick_any_s)
    );

    // Ready is only offered while idle and out of reset, so a grant can never race a reset edge.
    assign accept_s   = (state_q == ARB_IDLE) && !reset && pick_any_s;
    assign req_ready  = accept_s ? grant_s : '0;
    assign timeout_s  = (cnt_q == 16'(TIMEOUT));
    assign next_ptr_s = (winner_q == IDX_W'(NUM_REQ - 1)) ? '0 : winner_q + IDX_W'(1);

    // Next-state and datapath for the IDLE -> BUS -> RESP read sequence.
    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        rr_ptr_d    = rr_ptr_q;
        adr_d       = adr_q;
        cnt_d       = cnt_q;
        cyc_d       = cyc_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ARB_IDLE: begin
                if (accept_s) begin
                    state_d  = ARB_BUS;
                    winner_d = pick_idx_s;
                    adr_d    = adr_arr_s[pick_idx_s];
                    cnt_d    = 16'd0;
                    cyc_d    = 1'b1;
                end else begin
                    state_d  = ARB_IDLE;
                end
            end
            ARB_BUS: begin
                if (cfu_ram_err || cfu_ram_ack || timeout_s) begin
                    state_d     = ARB_RESP;
                    cyc_d       = 1'b0;
                    rsp_valid_d = NUM_REQ'(1) << winner_q;
                    // err beats a simultaneous ack; timeout reports as an error.
                    if (cfu_ram_ack && !cfu_ram_err) begin
                        rsp_data_d = cfu_ram_dat_miso;
                        rsp_err_d  = 1'b0;
                    end else begin
                        rsp_data_d = 32'd0;
                        rsp_err_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ARB_RESP: begin
                state_d  = ARB_IDLE;
                rr_ptr_d = next_ptr_s;
            end
            default: begin
                state_d = ARB_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            winner_q    <= '0;
            rr_ptr_q    <= '0;
            adr_q       <= '0;
            cnt_q       <= 16'd0;
            cyc_q       <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            rr_ptr_q    <= rr_ptr_d;
            adr_q       <= adr_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign cfu_ram_adr = adr_q;
    assign cfu_ram_cyc = cyc_q;
    assign cfu_ram_stb = cyc_q;
    assign cfu_ram_sel = WB_SEL_ALL;
    assign cfu_ram_we  = 1'b0;
    assign cfu_ram_cti = 3'd0;
    assign cfu_ram_bte = 2'd0;

endmodule

// File: tb/tb_cfu_ram_arbiter.sv
// Self-checking bench for cfu_ram_arbiter: directed scenarios plus random transactions
// checked against a transaction-level round-robin model.
module tb_cfu_ram_arbiter;

    localparam int NUM_REQ = 2;
    localparam int ADR_W   = 30;
    localparam int TIMEOUT = 4;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [ADR_W-1:0]         adr_v [NUM_REQ];
    logic [NUM_REQ*ADR_W-1:0] req_adr;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [31:0]              rsp_data;
    logic                     rsp_err;
    logic [ADR_W-1:0]         cfu_ram_adr;
    logic                     cfu_ram_cyc, cfu_ram_stb, cfu_ram_we;
    logic [3:0]               cfu_ram_sel;
    logic [2:0]               cfu_ram_cti;
    logic [1:0]               cfu_ram_bte;
    logic [31:0]              cfu_ram_dat_miso;
    logic                     cfu_ram_ack, cfu_ram_err;

    int          checks = 0;
    int          errors = 0;
    int          cycle_cnt = 0;
    int          ptr_m;
    logic [31:0] exp_data;
    logic        exp_err;

    assign req_adr = {adr_v[1], adr_v[0]};

    cfu_ram_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADR_W   (ADR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_adr          (req_adr),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .rsp_err          (rsp_err),
        .cfu_ram_adr      (cfu_ram_adr),
        .cfu_ram_cyc      (cfu_ram_cyc),
        .cfu_ram_stb      (cfu_ram_stb),
        .cfu_ram_sel      (cfu_ram_sel),
        .cfu_ram_we       (cfu_ram_we),
        .cfu_ram_cti      (cfu_ram_cti),
        .cfu_ram_bte      (cfu_ram_bte),
        .cfu_ram_dat_miso (cfu_ram_dat_miso),
        .cfu_ram_ack      (cfu_ram_ack),
        .cfu_ram_err      (cfu_ram_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_static();
        chk("sel", 64'(cfu_ram_sel), 64'hF);
        chk("we", 64'(cfu_ram_we), 64'h0);
        chk("cti", 64'(cfu_ram_cti), 64'h0);
        chk("bte", 64'(cfu_ram_bte), 64'h0);
        chk("rsp_data_hold", 64'(rsp_data), 64'(exp_data));
        chk("rsp_err_hold", 64'(rsp_err), 64'(exp_err));
    endtask

    // Round-robin rule: first requester at or after the pointer, wrapping around.
    function automatic int pick_m(input logic [NUM_REQ-1:0] mask);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (mask[(ptr_m + k) % NUM_REQ]) return (ptr_m + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // kind: 0 = ack, 1 = ack together with err, 2 = silent slave (timeout, late ack in RESP)
    task automatic run_txn(input logic [NUM_REQ-1:0] mask, input int waits, input int kind,
                           input logic [31:0] data, output int w_o, output int acc_o);
        int               w;
        int               ncyc;
        logic [ADR_W-1:0] a;
        chk("idle_cyc", 64'(cfu_ram_cyc), 64'h0);
        chk("idle_rsp_valid", 64'(rsp_valid), 64'h0);
        chk_static();
        req_valid = mask;
        #1;
        w = pick_m(mask);
        chk("ready_grant", 64'(req_ready), 64'(1 << w));
        a = adr_v[w];
        @(negedge clk);
        acc_o = cycle_cnt;
        req_valid[w] = 1'b0;
        adr_v[w] = ADR_W'($urandom);
        ncyc = (kind == 2) ? TIMEOUT + 1 : waits + 1;
        for (int c = 0; c < ncyc; c++) begin
            chk("bus_cyc", 64'(cfu_ram_cyc), 64'h1);
            chk("bus_stb", 64'(cfu_ram_stb), 64'h1);
            chk("bus_adr", 64'(cfu_ram_adr), 64'(a));
            chk("bus_ready", 64'(req_ready), 64'h0);
            chk("bus_rsp_valid", 64'(rsp_valid), 64'h0);
            chk_static();
            if (kind != 2 && c == waits) begin
                cfu_ram_ack      = 1'b1;
                cfu_ram_err      = (kind == 1);
                cfu_ram_dat_miso = data;
            end else begin
                cfu_ram_ack      = 1'b0;
                cfu_ram_err      = 1'b0;
                cfu_ram_dat_miso = $urandom;
            end
            @(negedge clk);
        end
        if (kind == 0) begin
            exp_data = data;
            exp_err  = 1'b0;
        end else begin
            exp_data = 32'd0;
            exp_err  = 1'b1;
        end
        cfu_ram_ack      = (kind == 2);
        cfu_ram_err      = 1'b0;
        cfu_ram_dat_miso = $urandom;
        chk("resp_cyc", 64'(cfu_ram_cyc), 64'h0);
        chk("resp_stb", 64'(cfu_ram_stb), 64'h0);
        chk("resp_valid", 64'(rsp_valid), 64'(1 << w));
        chk("resp_ready", 64'(req_ready), 64'h0);
        chk_static();
        ptr_m = (w + 1) % NUM_REQ;
        @(negedge clk);
        cfu_ram_ack = 1'b0;
        w_o = w;
    endtask

    initial begin
        int w, acc, prev_acc, kind_r;
        reset = 1'b1;
        req_valid = '0;
        adr_v[0] = '0;
        adr_v[1] = '0;
        cfu_ram_ack = 1'b0;
        cfu_ram_err = 1'b0;
        cfu_ram_dat_miso = 32'd0;
        ptr_m = 0;
        exp_data = 32'd0;
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cyc", 64'(cfu_ram_cyc), 64'h0);
        chk("rst_stb", 64'(cfu_ram_stb), 64'h0);
        chk("rst_adr", 64'(cfu_ram_adr), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk_static();
        reset = 1'b0;
        @(negedge clk);

        // Both requesting continuously, zero-wait: grants alternate with 3-cycle spacing.
        prev_acc = 0;
        for (int i = 0; i < 6; i++) begin
            adr_v[0] = ADR_W'($urandom);
            adr_v[1] = ADR_W'($urandom);
            run_txn(2'b11, 0, 0, $urandom, w, acc);
            chk("rr_order", 64'(w), 64'(i % 2));
            if (i > 0) chk("issue_spacing", 64'(acc - prev_acc), 64'd3);
            prev_acc = acc;
        end
        run_txn(2'b11, 0, 0, $urandom, w, acc);
        chk("ptr_wrapped", 64'(w), 64'd0);

        // Single request to 0x100 with two wait states.
        adr_v[0] = 30'h100;
        run_txn(2'b01, 2, 0, 32'hDEADBEEF, w, acc);
        chk("single_data", 64'(rsp_data), 64'hDEADBEEF);

        // err with ack: error wins, pointer still advances.
        run_txn(2'b11, 1, 1, 32'h12345678, w, acc);
        chk("err_winner", 64'(w), 64'd1);
        run_txn(2'b11, 0, 0, $urandom, w, acc);
        chk("err_advanced", 64'(w), 64'd0);

        // Silent slave times out; a stray ack in idle is ignored too.
        run_txn(2'b01, 0, 2, 32'hCAFEF00D, w, acc);
        cfu_ram_ack = 1'b1;
        cfu_ram_dat_miso = 32'h55AA55AA;
        @(negedge clk);
        cfu_ram_ack = 1'b0;
        chk("late_ack_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("late_ack_cyc", 64'(cfu_ram_cyc), 64'h0);
        chk_static();

        // Requester 1 alone, three times.
        for (int i = 0; i < 3; i++) begin
            adr_v[1] = ADR_W'($urandom);
            run_txn(2'b10, $urandom_range(0, 3), 0, $urandom, w, acc);
            chk("lone_winner", 64'(w), 64'd1);
        end

        // Reset while in BUS, with the pointer left non-zero beforehand.
        run_txn(2'b01, 0, 0, $urandom, w, acc);
        req_valid = 2'b10;
        #1;
        chk("pre_rst_ready", 64'(req_ready), 64'h2);
        @(negedge clk);
        chk("pre_rst_cyc", 64'(cfu_ram_cyc), 64'h1);
        req_valid = '0;
        reset = 1'b1;
        @(negedge clk);
        exp_data = 32'd0;
        exp_err = 1'b0;
        ptr_m = 0;
        chk("mid_rst_cyc", 64'(cfu_ram_cyc), 64'h0);
        chk("mid_rst_stb", 64'(cfu_ram_stb), 64'h0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk_static();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_rsp_valid", 64'(rsp_valid), 64'h0);
        run_txn(2'b11, 1, 0, $urandom, w, acc);
        chk("post_rst_winner", 64'(w), 64'd0);

        // Random transactions against the model.
        for (int i = 0; i < 30; i++) begin
            adr_v[0] = ADR_W'($urandom);
            adr_v[1] = ADR_W'($urandom);
            kind_r = $urandom_range(0, 5);
            run_txn(2'($urandom_range(1, 3)), $urandom_range(0, 3),
                    (kind_r < 4) ? 0 : kind_r - 3, $urandom, w, acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
